// File: rtl/data_arbiter_if.sv
// Bundle between the requesters, the round-robin arbiter and the consumer.
// master: producer/consumer side (drives requests and enable, observes issues).
// slave: arbiter side (accepts requests, drives issue strobe, grant and status).
interface data_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      enable;
  logic [DATA_W-1:0]         data_out;
  logic                      data_valid;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  modport master (
    output req_data, req_valid, enable,
    input  req_ready, data_out, data_valid, grant_id, busy
  );

  modport slave (
    input  req_data, req_valid, enable,
    output req_ready, data_out, data_valid, grant_id, busy
  );
endinterface

// File: rtl/data_arbiter.sv
// Round-robin arbiter: per-requester FIFOs feeding one consumer byte stream, with a minimum issue spacing.
// Latency: byte pushed on edge E into an idle, empty path is issued (data_valid=1) after edge E+1.
// Backpressure: req_ready[i] drops when FIFO i is full; the consumer side has none, GAP paces issues.
// Ports: clk, rst (async active-high), bus (slave modport): req_data/req_valid/req_ready per requester,
//        enable, data_out/data_valid issue strobe, grant_id of the last issue, busy = any FIFO non-empty.
module data_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP        = 0
) (
  input  logic          clk,
  input  logic          rst,
  data_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // FIFO storage and bookkeeping, one ring buffer per requester
  logic [DATA_W-1:0] mem    [NUM_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_REQ];
  logic [PTR_W-1:0]  rd_ptr [NUM_REQ];
  logic [CNT_W-1:0]  count  [NUM_REQ];

  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;

  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              issue;
  logic [3:0]        gap_cnt;

  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic [ID_W-1:0]   grant_q;

  // Readiness looks only at the current count, never at a same-cycle pop,
  // so a full FIFO refuses a byte even on the cycle it is being drained.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    push     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty[i] = (count[i] != '0);
      ready[i]    = (count[i] < CNT_W'(FIFO_DEPTH));
      push[i]     = bus.req_valid[i] && ready[i];
    end
  end

  assign issue = bus.enable && (gap_cnt == 4'd0) && (|nonempty);

  // Search starts one past the last grant and wraps, giving round-robin order.
  always_comb begin
    winner = last_grant;
    cand   = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && nonempty[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = issue && (winner == ID_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        // push and pop together leave the count unchanged
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Payload array needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      grant_q      <= '0;
      last_grant   <= ID_W'(NUM_REQ - 1);
      gap_cnt      <= 4'd0;
    end else begin
      data_valid_q <= issue;
      if (issue) begin
        data_out_q <= mem[winner][rd_ptr[winner]];
        grant_q    <= winner;
        last_grant <= winner;
        gap_cnt    <= 4'(GAP);
      end else if (gap_cnt != 4'd0) begin
        // spacing counter runs down even while enable is low
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.busy       = |nonempty;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.grant_id   = grant_q;

endmodule

// File: tb/tb_data_arbiter.sv
// Directed bench for data_arbiter: a GAP=0/depth-2 instance driven from a vector table,
// and a GAP=3/depth-4 instance for issue spacing; hand sequences cover async reset.
module tb_data_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b0 ();
  data_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) b3 ();

  data_arbiter #(.NUM_REQ(4), .DATA_W(8), .FIFO_DEPTH(2), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  data_arbiter #(.NUM_REQ(4), .DATA_W(8), .FIFO_DEPTH(4), .GAP(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rst_before;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        en;
    logic        e_dv;
    logic [7:0]  e_do;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic [3:0]  e_rdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] v, input logic [31:0] d, input logic en,
                     input logic dv, input logic [7:0] dout, input logic [1:0] g,
                     input logic b, input logic [3:0] rdy);
    vec_t x;
    x.rst_before = r; x.valid = v; x.data = d; x.en = en;
    x.e_dv = dv; x.e_do = dout; x.e_gid = g; x.e_busy = b; x.e_rdy = rdy;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk0(input string nm, input int idx, input logic dv, input logic [7:0] dout,
                      input logic [1:0] g, input logic b, input logic [3:0] rdy);
    chk({nm, "_dv"},   idx, 32'(b0.data_valid), 32'(dv));
    chk({nm, "_do"},   idx, 32'(b0.data_out),   32'(dout));
    chk({nm, "_gid"},  idx, 32'(b0.grant_id),   32'(g));
    chk({nm, "_busy"}, idx, 32'(b0.busy),       32'(b));
    chk({nm, "_rdy"},  idx, 32'(b0.req_ready),  32'(rdy));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b0.req_valid = '0; b0.enable = 1'b0;
    b3.req_valid = '0; b3.enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int nxt;
    logic exp_dv;

    rst = 1'b1;
    b0.req_data = '0; b0.req_valid = '0; b0.enable = 1'b0;
    b3.req_data = '0; b3.req_valid = '0; b3.enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state, both instances
    chk0("rst0", 0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    chk("rst3_dv",   0, 32'(b3.data_valid), 32'd0);
    chk("rst3_do",   0, 32'(b3.data_out),   32'd0);
    chk("rst3_gid",  0, 32'(b3.grant_id),   32'd0);
    chk("rst3_busy", 0, 32'(b3.busy),       32'd0);
    chk("rst3_rdy",  0, 32'(b3.req_ready),  32'hF);

    //  rst valid    data          en  dv  dout   gid busy rdy
    // single byte on req 2
    add(0, 4'b0100, 32'h00A5_0000, 1, 0, 8'h00, 0, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'hA5, 2, 0, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 0, 8'hA5, 2, 0, 4'b1111);
    // all four full, then 8 back-to-back round-robin issues
    add(1, 4'b1111, 32'h1312_1110, 0, 0, 8'h00, 0, 1, 4'b1111);
    add(0, 4'b1111, 32'h2322_2120, 0, 0, 8'h00, 0, 1, 4'b0000);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h10, 0, 1, 4'b0001);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h11, 1, 1, 4'b0011);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h12, 2, 1, 4'b0111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h13, 3, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h20, 0, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h21, 1, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h22, 2, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h23, 3, 0, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 0, 8'h23, 3, 0, 4'b1111);
    // enable low back-pressure on req 0, third byte held by producer
    add(1, 4'b0001, 32'h0000_0031, 0, 0, 8'h00, 0, 1, 4'b1111);
    add(0, 4'b0001, 32'h0000_0032, 0, 0, 8'h00, 0, 1, 4'b1110);
    add(0, 4'b0001, 32'h0000_0033, 0, 0, 8'h00, 0, 1, 4'b1110);
    add(0, 4'b0001, 32'h0000_0033, 1, 1, 8'h31, 0, 1, 4'b1111);
    add(0, 4'b0001, 32'h0000_0033, 0, 0, 8'h31, 0, 1, 4'b1110);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h32, 0, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h33, 0, 0, 4'b1111);
    // req 1: full FIFO refuses while popping, then push+pop hold the count
    add(0, 4'b0010, 32'h0000_5100, 0, 0, 8'h33, 0, 1, 4'b1111);
    add(0, 4'b0010, 32'h0000_5200, 0, 0, 8'h33, 0, 1, 4'b1101);
    add(0, 4'b0010, 32'h0000_5300, 1, 1, 8'h51, 1, 1, 4'b1111);
    add(0, 4'b0010, 32'h0000_5300, 1, 1, 8'h52, 1, 1, 4'b1111);
    add(0, 4'b0010, 32'h0000_5400, 1, 1, 8'h53, 1, 1, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 1, 8'h54, 1, 0, 4'b1111);
    add(0, 4'b0000, 32'h0,         1, 0, 8'h54, 1, 0, 4'b1111);

    foreach (tbl[k]) begin
      if (tbl[k].rst_before) do_reset();
      b0.req_valid = tbl[k].valid;
      b0.req_data  = tbl[k].data;
      b0.enable    = tbl[k].en;
      step();
      chk0("tbl", k, tbl[k].e_dv, tbl[k].e_do, tbl[k].e_gid, tbl[k].e_busy, tbl[k].e_rdy);
    end
    b0.req_valid = '0;
    b0.enable    = 1'b0;

    // GAP=3: three bytes on req 1, issues every 4th cycle in order
    do_reset();
    b3.req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      b3.req_data = {16'h0, 8'(8'h61 + k), 8'h0};
      step();
    end
    chk("gap_busy_pre", 0, 32'(b3.busy), 32'd1);
    chk("gap_dv_pre",   0, 32'(b3.data_valid), 32'd0);
    b3.req_valid = '0;
    b3.enable    = 1'b1;
    nxt = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_dv = ((k % 4) == 1);
      chk("gap_dv", k, 32'(b3.data_valid), 32'(exp_dv));
      if (exp_dv) begin
        chk("gap_do",  k, 32'(b3.data_out), 32'(8'h61 + nxt));
        chk("gap_gid", k, 32'(b3.grant_id), 32'd1);
        nxt++;
      end
    end
    chk("gap_busy_end", 0, 32'(b3.busy), 32'd0);
    b3.enable = 1'b0;

    // reset mid-stream with 5 bytes queued
    do_reset();
    b0.req_valid = 4'b0111; b0.req_data = 32'h0072_7170;
    step();
    b0.req_valid = 4'b0011; b0.req_data = 32'h0000_7473;
    step();
    chk0("mid_pre", 0, 1'b0, 8'h00, 2'd0, 1'b1, 4'b1100);
    b0.req_valid = '0;
    b0.enable    = 1'b1;
    step();
    chk0("mid_issue", 0, 1'b1, 8'h70, 2'd0, 1'b1, 4'b1101);
    #2;
    rst = 1'b1;
    #1;
    chk0("mid_async", 0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1111);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("post_dv",   k, 32'(b0.data_valid), 32'd0);
      chk("post_busy", k, 32'(b0.busy),       32'd0);
    end
    b0.req_valid = 4'b1001; b0.req_data = 32'h8300_0080;
    step();
    chk0("post_push", 0, 1'b0, 8'h00, 2'd0, 1'b1, 4'b1111);
    b0.req_valid = '0;
    step();
    chk0("post_first", 0, 1'b1, 8'h80, 2'd0, 1'b1, 4'b1111);
    step();
    chk0("post_second", 0, 1'b1, 8'h83, 2'd3, 1'b0, 4'b1111);
    step();
    chk("post_idle_dv", 0, 32'(b0.data_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
